// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: default widths, ALU control codes,
// the arbiter FSM state type and the control-code legality decode.
package alu_pkg;

    localparam int ALU_WIDTH  = 48;
    localparam int ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] CTRL_AND = 4'h0;
    localparam logic [ALU_CTRL_W-1:0] CTRL_OR  = 4'h1;
    localparam logic [ALU_CTRL_W-1:0] CTRL_ADD = 4'h2;
    localparam logic [ALU_CTRL_W-1:0] CTRL_SUB = 4'h6;
    localparam logic [ALU_CTRL_W-1:0] CTRL_SLT = 4'h7;
    localparam logic [ALU_CTRL_W-1:0] CTRL_NOR = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } arb_state_t;

    function automatic logic ctrl_legal(input logic [ALU_CTRL_W-1:0] code);
        case (code)
            CTRL_AND, CTRL_OR, CTRL_ADD,
            CTRL_SUB, CTRL_SLT, CTRL_NOR: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters, the arbiter and the
// response consumer. Requester i occupies slice i of the packed operand buses.
interface alu_arbiter_if #(
    parameter int WIDTH  = 48,
    parameter int CTRL_W = 4
) ();
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [2*WIDTH-1:0]  req_a;
    logic [2*WIDTH-1:0]  req_b;
    logic [2*CTRL_W-1:0] req_ctrl;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [WIDTH-1:0]    rsp_result;
    logic                rsp_zero;
    logic                rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu.sv
// Combinational ALU: AND, OR, ADD, SUB, signed SLT, NOR. Unsupported codes
// produce zero. ADD/SUB wrap modulo 2^WIDTH.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int CTRL_W = ALU_CTRL_W
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [WIDTH-1:0]  y,
    output logic              zero
);

    always_comb begin
        y = '0;
        case (ctrl)
            CTRL_AND: y = a & b;
            CTRL_OR:  y = a | b;
            CTRL_ADD: y = a + b;
            CTRL_SUB: y = a - b;
            CTRL_SLT: y = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            CTRL_NOR: y = ~(a | b);
            default:  y = '0;
        endcase
        zero = (y == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU: IDLE accepts one request, EXEC
// registers the result, RESP holds it until consumed. Tie-break is round-robin
// unless ALU_ARB_FIXED_PRIO_EN is defined (requester 0 always wins ties).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int CTRL_W = ALU_CTRL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    logic [WIDTH-1:0]  a_slice    [2];
    logic [WIDTH-1:0]  b_slice    [2];
    logic [CTRL_W-1:0] ctrl_slice [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slice
            assign a_slice[gi]    = bus.req_a[gi*WIDTH +: WIDTH];
            assign b_slice[gi]    = bus.req_b[gi*WIDTH +: WIDTH];
            assign ctrl_slice[gi] = bus.req_ctrl[gi*CTRL_W +: CTRL_W];
        end
    endgenerate

    arb_state_t        state_reg;
    logic              idle_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [CTRL_W-1:0] ctrl_reg;
    logic              id_reg;
    logic              rsp_valid_reg;
    logic              rsp_id_reg;
    logic [WIDTH-1:0]  rsp_result_reg;
    logic              rsp_zero_reg;
    logic              rsp_err_reg;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic              last_grant_reg;
`endif

    logic grant_id;
    logic transfer;

    always_comb begin
        grant_id = 1'b0;
        if (bus.req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant_id = 1'b0;
`else
            grant_id = ~last_grant_reg;
`endif
        end else if (bus.req_valid[1]) begin
            grant_id = 1'b1;
        end
    end

    // idle_reg is low during reset, so no requester sees ready until released.
    assign bus.req_ready = (idle_reg && state_reg == ST_IDLE)
                         ? ((grant_id ? 2'b10 : 2'b01) & bus.req_valid) : 2'b00;
    assign transfer      = idle_reg && (state_reg == ST_IDLE) && (|bus.req_valid);

    logic [WIDTH-1:0] alu_y;
    logic             alu_zero;
    logic             ctrl_err;

    alu #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) u_alu (
        .a    (a_reg),
        .b    (b_reg),
        .ctrl (ctrl_reg),
        .y    (alu_y),
        .zero (alu_zero)
    );

    assign ctrl_err = ~ctrl_legal(ctrl_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            idle_reg       <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            ctrl_reg       <= '0;
            id_reg         <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b0;
            rsp_err_reg    <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_reg <= 1'b1;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    idle_reg <= 1'b1;
                    if (transfer) begin
                        a_reg     <= a_slice[grant_id];
                        b_reg     <= b_slice[grant_id];
                        ctrl_reg  <= ctrl_slice[grant_id];
                        id_reg    <= grant_id;
                        idle_reg  <= 1'b0;
                        state_reg <= ST_EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant_reg <= grant_id;
`endif
                    end
                end
                ST_EXEC: begin
                    rsp_result_reg <= ctrl_err ? '0 : alu_y;
                    rsp_zero_reg   <= ctrl_err ? 1'b1 : alu_zero;
                    rsp_err_reg    <= ctrl_err;
                    rsp_id_reg     <= id_reg;
                    rsp_valid_reg  <= 1'b1;
                    state_reg      <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        idle_reg      <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    idle_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_id     = rsp_id_reg;
    assign bus.rsp_result = rsp_result_reg;
    assign bus.rsp_zero   = rsp_zero_reg;
    assign bus.rsp_err    = rsp_err_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, fairness and
// reset corner cases, then randomized ops against a behavioural model.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W  = 48;
    localparam int CW = 4;
    localparam logic [63:0] MASK = 64'h0000_FFFF_FFFF_FFFF;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam logic RR1 = 1'b0;
`else
    localparam logic RR1 = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(W), .CTRL_W(CW)) bus ();

    alu_arbiter #(.WIDTH(W), .CTRL_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    logic model_last = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural ALU: plain integer arithmetic on 64-bit values.
    function automatic void alu_ref(input logic [3:0] c, input logic [47:0] a, input logic [47:0] b,
                                    output logic [47:0] r, output logic z, output logic e);
        longint unsigned ua, ub, res;
        longint sa, sb;
        ua = 64'(a);
        ub = 64'(b);
        sa = longint'(ua) - (a[47] ? 64'sd281474976710656 : 64'sd0);
        sb = longint'(ub) - (b[47] ? 64'sd281474976710656 : 64'sd0);
        e = 1'b0;
        case (c)
            4'h0:    res = ua & ub;
            4'h1:    res = ua | ub;
            4'h2:    res = (ua + ub) & MASK;
            4'h6:    res = (ua - ub) & MASK;
            4'h7:    res = (sa < sb) ? 64'd1 : 64'd0;
            4'hC:    res = ~(ua | ub) & MASK;
            default: begin res = 0; e = 1'b1; end
        endcase
        r = res[47:0];
        z = (res == 0);
    endfunction

    function automatic logic model_grant(input logic [1:0] vm);
        if (vm == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            return 1'b0;
`else
            return ~model_last;
`endif
        end
        return vm[1];
    endfunction

    task automatic run_op(input logic [1:0] vm,
                          input logic [47:0] a0, input logic [47:0] b0, input logic [3:0] c0,
                          input logic [47:0] a1, input logic [47:0] b1, input logic [3:0] c1,
                          input int stall, input logic exp_id,
                          input logic [47:0] exp_res, input logic exp_zero, input logic exp_err);
        @(negedge clk);
        bus.req_valid = vm;
        bus.req_a     = {a1, a0};
        bus.req_b     = {b1, b0};
        bus.req_ctrl  = {c1, c0};
        bus.rsp_ready = 1'b0;
        #1;
        check("req_ready_idle", 64'(bus.req_ready), exp_id ? 64'd2 : 64'd1);
        @(negedge clk);
        check("rsp_valid_exec", 64'(bus.rsp_valid), 64'd0);
        check("req_ready_exec", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check("rsp_valid_resp", 64'(bus.rsp_valid), 64'd1);
        check("rsp_id", 64'(bus.rsp_id), 64'(exp_id));
        check("rsp_result", 64'(bus.rsp_result), 64'(exp_res));
        check("rsp_zero", 64'(bus.rsp_zero), 64'(exp_zero));
        check("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
        $display("op vm=%b ctrl0=%h ctrl1=%h id=%0d result=%h zero=%0d err=%0d stall=%0d",
                 vm, c0, c1, bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_err, stall);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("rsp_valid_hold", 64'(bus.rsp_valid), 64'd1);
            check("rsp_result_hold", 64'(bus.rsp_result), 64'(exp_res));
            check("req_ready_resp", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_valid_done", 64'(bus.rsp_valid), 64'd0);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 2'b00;
        model_last = exp_id;
    endtask

    typedef struct {
        logic [1:0]  vm;
        logic [47:0] a0, b0;
        logic [3:0]  c0;
        logic [47:0] a1, b1;
        logic [3:0]  c1;
        int          stall;
        logic        id;
        logic [47:0] res;
        logic        zero, err;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [47:0] ra0, rb0, ra1, rb1, er;
        logic [3:0]  rc0, rc1;
        logic [63:0] tmp;
        logic [1:0]  vm;
        logic        eid, ez, ee;
        logic [3:0]  codes [8];

        codes = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h9, 4'hF};

        tbl[0]  = '{2'b11, 48'd10, 48'd5, 4'h6, 48'd10, 48'd5, 4'h6, 0, 1'b0, 48'd5, 1'b0, 1'b0};
        tbl[1]  = '{2'b11, 48'd10, 48'd5, 4'h6, 48'd10, 48'd5, 4'h6, 0, RR1,  48'd5, 1'b0, 1'b0};
        tbl[2]  = '{2'b11, 48'd10, 48'd5, 4'h6, 48'd10, 48'd5, 4'h6, 0, 1'b0, 48'd5, 1'b0, 1'b0};
        tbl[3]  = '{2'b11, 48'd10, 48'd5, 4'h6, 48'd10, 48'd5, 4'h6, 0, RR1,  48'd5, 1'b0, 1'b0};
        tbl[4]  = '{2'b01, 48'd1, 48'd1, 4'h2, 48'd0, 48'd0, 4'h0, 0, 1'b0, 48'd2, 1'b0, 1'b0};
        tbl[5]  = '{2'b10, 48'd0, 48'd0, 4'h0, 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 4'h6, 5,
                    1'b1, 48'd0, 1'b1, 1'b0};
        tbl[6]  = '{2'b01, 48'hFFFF_FFFF_FFFD, 48'hFFFF_FFFF_FFFB, 4'h7, 48'd0, 48'd0, 4'h0, 0,
                    1'b0, 48'd0, 1'b1, 1'b0};
        tbl[7]  = '{2'b01, 48'd3, 48'd5, 4'h7, 48'd0, 48'd0, 4'h0, 1, 1'b0, 48'd1, 1'b0, 1'b0};
        tbl[8]  = '{2'b01, 48'd7, 48'd9, 4'h9, 48'd0, 48'd0, 4'h0, 0, 1'b0, 48'd0, 1'b1, 1'b1};
        tbl[9]  = '{2'b10, 48'd0, 48'd0, 4'h0, 48'hF0F0, 48'hFF00, 4'h0, 0, 1'b1, 48'hF000, 1'b0, 1'b0};
        tbl[10] = '{2'b01, 48'hF0F0, 48'hFF00, 4'h1, 48'd0, 48'd0, 4'h0, 0, 1'b0, 48'hFFF0, 1'b0, 1'b0};
        tbl[11] = '{2'b10, 48'd0, 48'd0, 4'h0, 48'hFFFF_FFFF_FFFF, 48'd2, 4'h2, 2, 1'b1, 48'd1, 1'b0, 1'b0};

        rst_n         = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_ctrl  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("reset_rsp_result", 64'(bus.rsp_result), 64'd0);
        check("reset_rsp_zero", 64'(bus.rsp_zero), 64'd0);
        check("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("reset_req_ready", 64'(bus.req_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].vm, tbl[i].a0, tbl[i].b0, tbl[i].c0, tbl[i].a1, tbl[i].b1, tbl[i].c1,
                   tbl[i].stall, tbl[i].id, tbl[i].res, tbl[i].zero, tbl[i].err);
        end

        // Requester 1 withdraws before being accepted; the tie that follows
        // must still be decided by the last accepted grant.
        @(negedge clk);
        bus.req_valid = 2'b10;
        #1;
        check("withdraw_ready", 64'(bus.req_ready), 64'd2);
        #2;
        bus.req_valid = 2'b00;
        eid = model_grant(2'b11);
        alu_ref(4'h2, eid ? 48'd40 : 48'd20, 48'd2, er, ez, ee);
        run_op(2'b11, 48'd20, 48'd2, 4'h2, 48'd40, 48'd2, 4'h2, 0, eid, er, ez, ee);

        // Reset while the operation is in EXEC: it must vanish.
        @(negedge clk);
        bus.req_valid = 2'b01;
        bus.req_a     = {48'd0, 48'd5};
        bus.req_b     = {48'd0, 48'd6};
        bus.req_ctrl  = {4'h0, 4'h2};
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_exec_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_exec_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("rst_exec_rsp_result", 64'(bus.rsp_result), 64'd0);
        check("rst_exec_rsp_zero", 64'(bus.rsp_zero), 64'd0);
        check("rst_exec_req_ready", 64'(bus.req_ready), 64'd0);
        bus.req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end

        for (int i = 0; i < 40; i++) begin
            vm  = 2'($urandom_range(1, 3));
            tmp = {$urandom, $urandom}; ra0 = tmp[47:0];
            tmp = {$urandom, $urandom}; rb0 = tmp[47:0];
            tmp = {$urandom, $urandom}; ra1 = tmp[47:0];
            tmp = {$urandom, $urandom}; rb1 = tmp[47:0];
            if ($urandom_range(0, 3) == 0) rb0 = ra0;
            if ($urandom_range(0, 3) == 0) rb1 = ra1;
            rc0 = codes[$urandom_range(0, 7)];
            rc1 = codes[$urandom_range(0, 7)];
            eid = model_grant(vm);
            if (eid) alu_ref(rc1, ra1, rb1, er, ez, ee);
            else     alu_ref(rc0, ra0, rb0, er, ez, ee);
            run_op(vm, ra0, rb0, rc0, ra1, rb1, rc1, $urandom_range(0, 2), eid, er, ez, ee);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
